cache_wb_buffer: RTL and testbench
==================================

// Module: cache_wb_buffer
// PURPOSE
//  Write-back buffer between the cache line-swap port and main_mem. Absorbs dirty-line evictions (up_gnt after
//  1 cycle instead of full memory latency), drains them to memory in the background, and serves line reads
//  either from a matching buffered entry or from memory. Upstream port mirrors the main_mem line interface.
// PARAMETERS
//  LINE_ADDR_LEN  3   log2 words per line; LINE_SIZE = 1<<LINE_ADDR_LEN
//  ADDR_LEN       9   line address width ({tag,set})
//  DEPTH          4   buffer entries, power of 2, >=2
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous, active-high reset
//  up_addr      in   ADDR_LEN             line address of upstream request
//  up_rd_req    in   1                    line read request, held until up_gnt
//  up_wr_req    in   1                    line write (eviction) request, held until up_gnt
//  up_wr_line   in   32 x LINE_SIZE       eviction data
//  up_rd_line   out  32 x LINE_SIZE       read data, valid in up_gnt cycle, held until next read grant
//  up_gnt       out  1                    one-cycle grant pulse
//  mem_addr     out  ADDR_LEN             address of active memory request, 0 when none
//  mem_rd_req   out  1                    memory line read, held until mem_gnt
//  mem_wr_req   out  1                    memory line write (drain), held until mem_gnt
//  mem_wr_line  out  32 x LINE_SIZE       drain data
//  mem_rd_line  in   32 x LINE_SIZE       memory read data, valid with mem_gnt
//  mem_gnt      in   1                    memory grant pulse
//  wb_count     out  $clog2(DEPTH)+1      occupied entries
// BEHAVIOUR
//  - Storage: DEPTH entries {valid, addr, line}, circular FIFO with head (oldest) and tail pointers; pointers wrap.
//  - Reset: all valid=0 (buffered data discarded), pointers 0, state IDLE; every output 0. Reset mid-drain drops
//    mem_wr_req on the next edge.
//  - Upstream: a request is accepted once. up_gnt pulses exactly 1 cycle. In the cycle after up_gnt, up_*_req is
//    ignored (requester drops it then). up_rd_req and up_wr_req together: treated as a write.
//  - Write: an entry with equal addr that is not the entry currently draining is overwritten in place (coalesce,
//    count unchanged); otherwise push at tail. Registered; up_gnt the cycle after req is first seen.
//    Full and no coalesce: stall (no gnt) until a drain pops; push and pop in the same cycle are legal.
//    Writes are serviced in every FSM state.
//  - Read: addr matches a valid entry -> up_rd_line = entry line, up_gnt 1 cycle later, no memory traffic.
//    No match -> RD_MEM; a read has priority over starting a new drain.
//  - FSM: IDLE -> RD_MEM on read miss; IDLE -> DRAIN when count>0 and no read pending.
//    RD_MEM: mem_rd_req=1, mem_addr=up_addr; on mem_gnt capture mem_rd_line -> ACK.
//    ACK: up_gnt=1 for the read -> IDLE.
//    DRAIN: mem_wr_req=1, mem_addr/mem_wr_line=head entry; on mem_gnt pop head -> IDLE.
//    A drain in progress always completes before a read miss is issued (read waits, no gnt).
//  - Read match against the draining head entry: forwarded from the buffer. Data stays valid until the pop.
//  - mem_rd_req and mem_wr_req are never both 1. wb_count == number of valid entries, 0..DEPTH.
// CONFIGURATION
//  WB_FORWARD_EN defined: read-hit forwarding from the buffer as above.
//  Not defined: no forwarding. Any upstream read waits until wb_count==0 (draining continues), then goes RD_MEM.
//  Write behaviour is identical in both builds.
// TESTING
//  1 wr A=0x012 line L0 -> up_gnt at cycle+1, wb_count=1; later mem_wr_req addr 0x012 data L0; pop -> wb_count=0.
//  2 wr 0x012 L0 then wr 0x012 L1 (not yet draining) -> wb_count=1; memory sees only L1.
//  3 Fill 4 distinct writes, mem_gnt held low, 5th write -> no up_gnt until first mem_gnt; then granted, count=4.
//  4 FORWARD_EN: wr 0x0A5 L2, rd 0x0A5 -> up_rd_line=L2, up_gnt in 1 cycle, no mem_rd_req.
//    Without it: rd waits for count=0, then reads memory.
//  5 rd 0x100 (miss) during active drain -> mem_rd_req only after drain mem_gnt; up_gnt 1 cycle after read mem_gnt.
//  6 Assert rst during DRAIN with 3 entries -> next cycle mem_wr_req=0, wb_count=0, up_gnt=0, state IDLE.

Source files
------------

// File: rtl/cache_wb_buffer.sv
// rtl/cache_wb_buffer.sv - write-back buffer between the cache line-swap port and main memory
//
// Evicted dirty lines are absorbed into a small circular FIFO and granted one
// cycle after the request. They drain to memory in the background, oldest first.
// Line reads are served from memory. When WB_FORWARD_EN is defined, a read whose
// address matches a buffered entry is answered from that entry instead.
//
// Optional feature macro: WB_FORWARD_EN
//   defined     : read hits are forwarded from the buffer. A read miss takes
//                 priority over starting a new drain.
//   not defined : a read waits until the buffer is empty (draining continues),
//                 then reads memory.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   up_addr                    line address of the upstream request
//   up_rd_req, up_wr_req       upstream line read / write requests, held until up_gnt
//   up_wr_line                 eviction data
//   up_rd_line                 read data, held until the next read grant
//   up_gnt                     one-cycle upstream grant pulse
//   mem_addr                   address of the active memory request, 0 when idle
//   mem_rd_req, mem_wr_req     memory line read / write (drain), held until mem_gnt
//   mem_wr_line, mem_rd_line   drain data / memory read data
//   mem_gnt                    memory grant pulse
//   wb_count                   number of occupied buffer entries
module cache_wb_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int DEPTH         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_LEN-1:0]               up_addr,
    input  logic                              up_rd_req,
    input  logic                              up_wr_req,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]    up_wr_line,
    output logic [(32<<LINE_ADDR_LEN)-1:0]    up_rd_line,
    output logic                              up_gnt,
    output logic [ADDR_LEN-1:0]               mem_addr,
    output logic                              mem_rd_req,
    output logic                              mem_wr_req,
    output logic [(32<<LINE_ADDR_LEN)-1:0]    mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]    mem_rd_line,
    input  logic                              mem_gnt,
    output logic [$clog2(DEPTH):0]            wb_count
);

    localparam int LINE_W = 32 << LINE_ADDR_LEN;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RD_MEM, ACK, DRAIN} state_t;

    state_t              state;
    logic [DEPTH-1:0]    ent_valid;
    logic [ADDR_LEN-1:0] ent_addr [DEPTH];
    logic [LINE_W-1:0]   ent_line [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;

    logic                wr_req_v;
    logic                rd_req_v;
    logic                drain_start;
    logic                head_locked;
    logic                pop;
    logic                push;
    logic                coal;
    logic                can_push;
    logic                wr_hit;
    logic [PTR_W-1:0]    wr_idx;
    logic [PTR_W-1:0]    scan_idx;
`ifdef WB_FORWARD_EN
    logic                rd_hit;
    logic [PTR_W-1:0]    rd_idx;
`endif

    // A request seen in the grant cycle is the one just granted; it is ignored.
    assign wr_req_v = up_wr_req && !up_gnt;
    assign rd_req_v = up_rd_req && !up_wr_req && !up_gnt;

`ifdef WB_FORWARD_EN
    assign drain_start = (state == IDLE) && (wb_count != '0) && !rd_req_v;
`else
    assign drain_start = (state == IDLE) && (wb_count != '0);
`endif

    // The head is frozen from the cycle its drain is launched (mem_wr_line is
    // captured on that edge), so a same-cycle write must not coalesce into it.
    assign head_locked = (state == DRAIN) || drain_start;
    assign pop         = (state == DRAIN) && mem_gnt;
    assign can_push    = (wb_count != CNT_W'(DEPTH)) || pop;
    assign coal        = wr_req_v && wr_hit;
    assign push        = wr_req_v && !wr_hit && can_push;

    // Scan oldest to newest so the last match is the youngest copy of a line.
    always_comb begin
        wr_hit   = 1'b0;
        wr_idx   = '0;
        scan_idx = '0;
`ifdef WB_FORWARD_EN
        rd_hit   = 1'b0;
        rd_idx   = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (ent_valid[scan_idx] && ent_addr[scan_idx] == up_addr) begin
`ifdef WB_FORWARD_EN
                rd_hit = 1'b1;
                rd_idx = scan_idx;
`endif
                if (!(head_locked && scan_idx == head)) begin
                    wr_hit = 1'b1;
                    wr_idx = scan_idx;
                end
            end
        end
    end

    // Entry payload needs no reset; ent_valid qualifies it.
    always_ff @(posedge clk) begin
        if (coal) begin
            ent_line[wr_idx] <= up_wr_line;
        end
        if (push) begin
            ent_addr[tail] <= up_addr;
            ent_line[tail] <= up_wr_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ent_valid   <= '0;
            head        <= '0;
            tail        <= '0;
            wb_count    <= '0;
            up_gnt      <= 1'b0;
            up_rd_line  <= '0;
            mem_addr    <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_wr_line <= '0;
        end else begin
            up_gnt <= 1'b0;

            // Pop before push: when full, head == tail and the push must win.
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (push || coal) begin
                up_gnt <= 1'b1;
            end
            wb_count <= wb_count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
`ifdef WB_FORWARD_EN
                    if (rd_req_v) begin
                        if (rd_hit) begin
                            up_rd_line <= ent_line[rd_idx];
                            up_gnt     <= 1'b1;
                        end else begin
                            state      <= RD_MEM;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= up_addr;
                        end
                    end else if (drain_start) begin
                        state       <= DRAIN;
                        mem_wr_req  <= 1'b1;
                        mem_addr    <= ent_addr[head];
                        mem_wr_line <= ent_line[head];
                    end
`else
                    if (drain_start) begin
                        state       <= DRAIN;
                        mem_wr_req  <= 1'b1;
                        mem_addr    <= ent_addr[head];
                        mem_wr_line <= ent_line[head];
                    end else if (rd_req_v) begin
                        state      <= RD_MEM;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= up_addr;
                    end
`endif
                end
                RD_MEM: begin
                    if (mem_gnt) begin
                        state      <= ACK;
                        up_rd_line <= mem_rd_line;
                        up_gnt     <= 1'b1;
                        mem_rd_req <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                DRAIN: begin
`ifdef WB_FORWARD_EN
                    // The draining head is still valid until the pop edge.
                    if (rd_req_v && rd_hit) begin
                        up_rd_line <= ent_line[rd_idx];
                        up_gnt     <= 1'b1;
                    end
`endif
                    if (mem_gnt) begin
                        state       <= IDLE;
                        mem_wr_req  <= 1'b0;
                        mem_addr    <= '0;
                        mem_wr_line <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb/tb_cache_wb_buffer.sv - directed self-checking bench for cache_wb_buffer
`timescale 1ns/1ps
module tb_cache_wb_buffer;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [8:0]    up_addr;
    logic          up_rd_req;
    logic          up_wr_req;
    logic [LW-1:0] up_wr_line;
    logic [LW-1:0] up_rd_line;
    logic          up_gnt;
    logic [8:0]    mem_addr;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [LW-1:0] mem_wr_line;
    logic [LW-1:0] mem_rd_line;
    logic          mem_gnt;
    logic [2:0]    wb_count;

    int n_cmp = 0;
    int n_err = 0;
    int rd_seen = 0;

    cache_wb_buffer #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .up_addr(up_addr), .up_rd_req(up_rd_req), .up_wr_req(up_wr_req),
        .up_wr_line(up_wr_line), .up_rd_line(up_rd_line), .up_gnt(up_gnt),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_rd_req) rd_seen++;

    function automatic logic [LW-1:0] mk(input logic [7:0] s);
        logic [LW-1:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {s, 8'hC3, 8'(w), ~s};
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns one cycle after the grant cycle; lat counts cycles from request to grant.
    task automatic wr(input logic [8:0] a, input logic [LW-1:0] d, output int lat);
        up_addr = a; up_wr_line = d; up_wr_req = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!up_gnt && lat < 60);
        up_wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [8:0] a, output int lat, output logic [LW-1:0] data);
        up_addr = a; up_rd_req = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!up_gnt && lat < 60);
        data = up_rd_line;
        up_rd_req = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a memory request, grants it for one cycle, returns in the cycle after.
    task automatic mem_ack(input logic [LW-1:0] rdata, output logic [8:0] a,
                           output logic [LW-1:0] wdata, output logic was_wr);
        int n = 0;
        while (!(mem_wr_req || mem_rd_req) && n < 60) begin @(negedge clk); n++; end
        chk("mem_req_seen", LW'(mem_wr_req || mem_rd_req), LW'(1));
        chk("mem_req_mutex", LW'(mem_wr_req && mem_rd_req), LW'(0));
        a = mem_addr; wdata = mem_wr_line; was_wr = mem_wr_req;
        mem_rd_line = rdata; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
    endtask

    initial begin
        int lat;
        int rd_base;
        logic [8:0]    a;
        logic [LW-1:0] d;
        logic          w;

        rst = 1'b1; up_addr = '0; up_rd_req = 0; up_wr_req = 0; up_wr_line = '0;
        mem_rd_line = '0; mem_gnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_up_gnt", LW'(up_gnt), LW'(0));
        chk("rst_mem_req", LW'({mem_rd_req, mem_wr_req}), LW'(0));
        chk("rst_mem_addr", LW'(mem_addr), LW'(0));
        chk("rst_wb_count", LW'(wb_count), LW'(0));
        chk("rst_up_rd_line", up_rd_line, '0);
        chk("rst_mem_wr_line", mem_wr_line, '0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single eviction, then drain
        wr(9'h012, mk(8'h10), lat);
        chk("t1_lat", LW'(lat), LW'(1));
        chk("t1_count", LW'(wb_count), LW'(1));
        chk("t1_mem_wr_req", LW'(mem_wr_req), LW'(1));
        chk("t1_mem_addr", LW'(mem_addr), LW'(9'h012));
        chk("t1_mem_wr_line", mem_wr_line, mk(8'h10));
        mem_gnt = 1'b1; @(negedge clk); mem_gnt = 1'b0;
        chk("t1_count_pop", LW'(wb_count), LW'(0));
        chk("t1_mem_idle", LW'({mem_wr_req, mem_addr}), LW'(0));

        // 2: coalesce into a non-draining entry while another line drains
        wr(9'h050, mk(8'h20), lat);
        chk("t2_lat_a", LW'(lat), LW'(1));
        wr(9'h012, mk(8'h11), lat);
        chk("t2_lat_b", LW'(lat), LW'(1));
        chk("t2_count_b", LW'(wb_count), LW'(2));
        wr(9'h012, mk(8'h12), lat);
        chk("t2_lat_c", LW'(lat), LW'(1));
        chk("t2_count_coal", LW'(wb_count), LW'(2));
        mem_ack('0, a, d, w);
        chk("t2_drain1_addr", LW'(a), LW'(9'h050));
        chk("t2_drain1_data", d, mk(8'h20));
        mem_ack('0, a, d, w);
        chk("t2_drain2_addr", LW'(a), LW'(9'h012));
        chk("t2_drain2_data", d, mk(8'h12));
        chk("t2_count_end", LW'(wb_count), LW'(0));

        // 3: full buffer stalls a fifth write until a drain pops
        for (int i = 0; i < 4; i++) begin
            wr(9'h020 + 9'(i), mk(8'h30 + 8'(i)), lat);
            chk("t3_fill_lat", LW'(lat), LW'(1));
        end
        chk("t3_count_full", LW'(wb_count), LW'(4));
        up_addr = 9'h024; up_wr_line = mk(8'h34); up_wr_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t3_stall_no_gnt", LW'(up_gnt), LW'(0));
        end
        chk("t3_drain_head", LW'(mem_addr), LW'(9'h020));
        mem_gnt = 1'b1; @(negedge clk); mem_gnt = 1'b0;
        chk("t3_gnt_after_pop", LW'(up_gnt), LW'(1));
        chk("t3_count_still_full", LW'(wb_count), LW'(4));
        up_wr_req = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 5; i++) begin
            mem_ack('0, a, d, w);
            chk("t3_drain_addr", LW'(a), LW'(9'h020 + 9'(i)));
            chk("t3_drain_data", d, mk(8'h30 + 8'(i)));
        end
        chk("t3_count_empty", LW'(wb_count), LW'(0));
        chk("t3_no_mem_reads", LW'(rd_seen), LW'(0));

        // 4: read of a buffered line
        wr(9'h0A5, mk(8'h40), lat);
        rd_base = rd_seen;
`ifdef WB_FORWARD_EN
        rd(9'h0A5, lat, d);
        chk("t4_fwd_lat", LW'(lat), LW'(1));
        chk("t4_fwd_data", d, mk(8'h40));
        chk("t4_fwd_no_mem_rd", LW'(rd_seen - rd_base), LW'(0));
        mem_ack('0, a, d, w);
        chk("t4_drain_addr", LW'(a), LW'(9'h0A5));
`else
        up_addr = 9'h0A5; up_rd_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_wait_no_gnt", LW'(up_gnt), LW'(0));
            chk("t4_wait_no_mem_rd", LW'(mem_rd_req), LW'(0));
        end
        mem_ack('0, a, d, w);
        chk("t4_drain_first", LW'({w, a}), LW'({1'b1, 9'h0A5}));
        chk("t4_drain_data", d, mk(8'h40));
        mem_ack(mk(8'h41), a, d, w);
        chk("t4_mem_rd", LW'({w, a}), LW'({1'b0, 9'h0A5}));
        chk("t4_rd_gnt", LW'(up_gnt), LW'(1));
        chk("t4_rd_data", up_rd_line, mk(8'h41));
        up_rd_req = 1'b0;
        @(negedge clk);
`endif
        chk("t4_count_end", LW'(wb_count), LW'(0));

        // 5: read miss during an active drain waits for the drain
        wr(9'h033, mk(8'h50), lat);
        up_addr = 9'h100; up_rd_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_mem_rd", LW'(mem_rd_req), LW'(0));
            chk("t5_no_gnt", LW'(up_gnt), LW'(0));
        end
        mem_ack('0, a, d, w);
        chk("t5_drain", LW'({w, a}), LW'({1'b1, 9'h033}));
        mem_ack(mk(8'h51), a, d, w);
        chk("t5_mem_rd", LW'({w, a}), LW'({1'b0, 9'h100}));
        chk("t5_gnt", LW'(up_gnt), LW'(1));
        chk("t5_rd_data", up_rd_line, mk(8'h51));
        up_rd_req = 1'b0;
        @(negedge clk);
        chk("t5_gnt_pulse", LW'(up_gnt), LW'(0));
        chk("t5_rd_data_held", up_rd_line, mk(8'h51));

        // 6: reset during a drain with three entries
        wr(9'h061, mk(8'h61), lat);
        wr(9'h062, mk(8'h62), lat);
        wr(9'h063, mk(8'h63), lat);
        chk("t6_count", LW'(wb_count), LW'(3));
        chk("t6_draining", LW'(mem_wr_req), LW'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_mem_wr_req", LW'(mem_wr_req), LW'(0));
        chk("t6_rst_count", LW'(wb_count), LW'(0));
        chk("t6_rst_gnt", LW'(up_gnt), LW'(0));
        chk("t6_rst_mem_addr", LW'(mem_addr), LW'(0));
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle_after_rst", LW'({mem_wr_req, mem_rd_req}), LW'(0));
        end
        wr(9'h077, mk(8'h77), lat);
        chk("t6_post_lat", LW'(lat), LW'(1));
        mem_ack('0, a, d, w);
        chk("t6_post_drain_addr", LW'(a), LW'(9'h077));
        chk("t6_post_drain_data", d, mk(8'h77));
        chk("t6_post_count", LW'(wb_count), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
